multicycle_controller: RTL and testbench
========================================

// Module: multicycle_controller
// PURPOSE
// - Control FSM for the multicycle RV32I core: sequences the shared ALU, register file, immediate unit and unified memory port.
// - Each instruction takes several clocks. Decode reuses the opcode/funct fields and the comparator flags (equal, less_than, less_than_unsigned).
// - Sits beside the datapath. Every mux select, write enable and memory request comes from here.
// PARAMETERS
// - RESET_STATE  4'd0  encoding of FETCH. The FSM enters it on reset.
// PORTS
// - clk                 input   1  core clock; all state changes on posedge
// - reset               input   1  asynchronous, active-high; returns FSM to FETCH
// - opcode              input   7  instr[6:0] from instruction register
// - funct3              input   3  instr[14:12]
// - funct7_5            input   1  instr[30]
// - equal               input   1  rs1 == rs2 (datapath comparator)
// - less_than           input   1  signed rs1 < rs2
// - less_than_unsigned  input   1  unsigned rs1 < rs2
// - mem_ready           input   1  memory done this cycle (read data valid / write accepted)
// - mem_req             output  1  memory access request; held until mem_ready
// - mem_write           output  1  request is a store
// - adr_src             output  1  0 = PC, 1 = ALUOut drives address
// - ir_write            output  1  load instr reg + old_pc
// - pc_write            output  1  load PC from result bus
// - reg_write           output  1  register file write enable
// - alu_src_a           output  2  00 = PC, 01 = old_pc, 10 = rs1 reg A, 11 = zero
// - alu_src_b           output  2  00 = rs2 reg B, 01 = imm, 10 = const 4
// - alu_control         output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu
// - result_src          output  2  00 = ALUOut, 01 = mem data reg, 10 = ALU result
// - immediate_control   output  3  000 I, 001 S, 010 B, 011 J, 100 U; combinational from opcode only
// - instr_retired       output  1  1-cycle pulse in the final cycle of each instruction
// - illegal_instr       output  1  sticky flag (only with ILLEGAL_TRAP_EN; otherwise tied 0)
// BEHAVIOUR
// - Reset: while reset = 1, all outputs 0 and state = FETCH. Asserting reset mid-instruction aborts it; no partial reg/mem/PC write after.
// - Moore FSM except ir_write/pc_write/instr_retired in wait states, which are gated by mem_ready.
// - FETCH: mem_req=1, adr_src=0, a=00, b=10, add, result_src=10. On mem_ready: ir_write=1, pc_write=1, go to DECODE; else stay.
// - DECODE (1 cycle): a=01, b=01, add (branch/JAL target into ALUOut). Next state by opcode:
//   - 0000011 / 0100011 / 1100111 -> MEM_ADR / MEM_ADR / JALR_ADR
//   - 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH; 1101111 -> JAL
//   - 0110111 / 0010111 -> LUI / AUIPC
//   - other -> illegal handling (see CONFIGURATION)
// - MEM_ADR: a=10, b=01, add. Then MEM_READ (load) or MEM_WRITE (store).
// - MEM_READ: mem_req=1, adr_src=1; wait for mem_ready, then MEM_WB.
// - MEM_WB: result_src=01, reg_write=1, instr_retired=1. Next FETCH.
// - MEM_WRITE: mem_req=1, mem_write=1, adr_src=1. On mem_ready: instr_retired=1, go to FETCH.
// - EXEC_R: a=10, b=00. EXEC_I: a=10, b=01. Both then go to ALU_WB.
// - ALU op from funct3: 000 add (sub if R-type and funct7_5), 001 sll, 010 slt, 011 sltu, 100 xor, 101 srl/sra by funct7_5, 110 or, 111 and.
// - LUI: a=11, b=01, add. AUIPC: a=01, b=01, add. Both then ALU_WB.
// - ALU_WB: result_src=00, reg_write=1, instr_retired=1. Next FETCH.
// - BRANCH: result_src=00, instr_retired=1, pc_write=taken. Next FETCH.
//   - taken by funct3: 000 eq, 001 !eq, 100 lt, 101 !lt, 110 ltu, 111 !ltu.
//   - funct3 010/011 is illegal; detected in DECODE.
// - JALR_ADR: a=10, b=01, add (rs1+imm). Next JAL.
// - JAL: pc_write=1, result_src=00; a=01, b=10, add (old_pc+4). Next ALU_WB.
// - JALR target bit 0 is cleared by the datapath, not here.
// - mem_ready outside a request state is ignored. mem_ready in the same cycle as mem_req entry completes that cycle (0 wait).
// - Latencies (mem_ready immediate): load 5, store 4, R/I/U 4, JAL/JALR 4/5, branch 3 clocks.
// CONFIGURATION
// - ILLEGAL_TRAP_EN defined:
//   - Illegal opcode or branch funct3 -> TRAP: all enables 0, illegal_instr=1.
//   - FSM stays in TRAP until reset; no instr_retired.
// - ILLEGAL_TRAP_EN undefined:
//   - Illegal instruction is a NOP: DECODE -> FETCH, instr_retired=1, no writes.
//   - illegal_instr tied 0.
// TESTING
// - Reset during MEM_READ wait (mem_ready=0) -> outputs 0 at once; after release FETCH with mem_req=1, no reg_write ever seen.
// - lw x5,8(x1) with mem_ready=1 each request -> FETCH, DECODE, MEM_ADR, MEM_READ, MEM_WB.
//   - reg_write=1 with result_src=01 only in cycle 5; instr_retired once.
// - sw with mem_ready delayed 3 cycles in MEM_WRITE -> mem_req=mem_write=1 held 4 cycles, then FETCH; reg_write never 1.
// - Branches -> pc_write only when taken:
//   - bne equal=1 -> not taken, pc_write=0 in BRANCH.
//   - bltu less_than_unsigned=1 -> taken, pc_write=1.
// - sub (0110011, f3=000, f7_5=1) -> alu_control=0001 in EXEC_R.
//   - srai (0010011, f3=101, f7_5=1) -> alu_control=0111 in EXEC_I.
// - opcode 7'b1111111:
//   - with ILLEGAL_TRAP_EN -> illegal_instr=1, FSM stuck, no mem_req, until reset.
//   - without -> back to FETCH next cycle, instr_retired pulse.

Source files
------------

// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle RV32I control FSM; define ILLEGAL_TRAP_EN to trap on illegal instructions
module multicycle_controller #(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  input  logic       equal,
  input  logic       less_than,
  input  logic       less_than_unsigned,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_write,
  output logic       adr_src,
  output logic       ir_write,
  output logic       pc_write,
  output logic       reg_write,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [3:0] alu_control,
  output logic [1:0] result_src,
  output logic [2:0] immediate_control,
  output logic       instr_retired,
  output logic       illegal_instr
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE, MEM_ADR, MEM_READ, MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
    ALU_WB, BRANCH, JALR_ADR, JAL, LUI, AUIPC, TRAP
  } state_t;
  state_t state, next_state, decode_next;
  logic legal, cmp, taken;
  logic [3:0] alu_op;
  // state register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= state_t'(RESET_STATE);
    else state <= next_state;
  // opcode dispatch; FETCH here marks an unknown opcode
  always_comb begin
    case (opcode)
      7'b0000011, 7'b0100011: decode_next = MEM_ADR;
      7'b1100111: decode_next = JALR_ADR;
      7'b0110011: decode_next = EXEC_R;
      7'b0010011: decode_next = EXEC_I;
      7'b1100011: decode_next = BRANCH;
      7'b1101111: decode_next = JAL;
      7'b0110111: decode_next = LUI;
      7'b0010111: decode_next = AUIPC;
      default:    decode_next = FETCH;
    endcase
  end
  assign legal = decode_next != FETCH && !(decode_next == BRANCH && funct3[2:1] == 2'b01);
  assign cmp = funct3[2] ? (funct3[1] ? less_than_unsigned : less_than) : equal;
  assign taken = cmp ^ funct3[0];
  // ALU operation from funct3; sub only for R-type (opcode bit 5 set)
  always_comb begin
    case (funct3)
      3'b000:  alu_op = (opcode[5] && funct7_5) ? 4'b0001 : 4'b0000;
      3'b001:  alu_op = 4'b0101;
      3'b010:  alu_op = 4'b1000;
      3'b011:  alu_op = 4'b1001;
      3'b100:  alu_op = 4'b0100;
      3'b101:  alu_op = funct7_5 ? 4'b0111 : 4'b0110;
      3'b110:  alu_op = 4'b0011;
      default: alu_op = 4'b0010;
    endcase
  end
  // immediate format select, forced low while reset is held
  always_comb begin
    case (opcode)
      7'b0100011:             immediate_control = 3'b001;
      7'b1100011:             immediate_control = 3'b010;
      7'b1101111:             immediate_control = 3'b011;
      7'b0110111, 7'b0010111: immediate_control = 3'b100;
      default:                immediate_control = 3'b000;
    endcase
    if (reset) immediate_control = 3'b000;
  end
  // next state and datapath controls; wait-state enables gated by mem_ready
  always_comb begin
    next_state = state;
    mem_req = 1'b0;
    mem_write = 1'b0;
    adr_src = 1'b0;
    ir_write = 1'b0;
    pc_write = 1'b0;
    reg_write = 1'b0;
    instr_retired = 1'b0;
    alu_src_a = 2'b00;
    alu_src_b = 2'b00;
    alu_control = 4'b0000;
    result_src = 2'b00;
    case (state)
      FETCH: begin
        mem_req = 1'b1;
        alu_src_b = 2'b10;
        result_src = 2'b10;
        ir_write = mem_ready;
        pc_write = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
`ifdef ILLEGAL_TRAP_EN
        next_state = legal ? decode_next : TRAP;
`else
        next_state = legal ? decode_next : FETCH;
        instr_retired = !legal;
`endif
      end
      MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next_state = opcode[5] ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        next_state = mem_ready ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        result_src = 2'b01;
        reg_write = 1'b1;
        instr_retired = 1'b1;
        next_state = FETCH;
      end
      MEM_WRITE: begin
        mem_req = 1'b1;
        mem_write = 1'b1;
        adr_src = 1'b1;
        instr_retired = mem_ready;
        next_state = mem_ready ? FETCH : MEM_WRITE;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_control = alu_op;
        next_state = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_control = alu_op;
        next_state = ALU_WB;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        next_state = ALU_WB;
      end
      AUIPC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        next_state = ALU_WB;
      end
      ALU_WB: begin
        reg_write = 1'b1;
        instr_retired = 1'b1;
        next_state = FETCH;
      end
      BRANCH: begin
        pc_write = taken;
        instr_retired = 1'b1;
        next_state = FETCH;
      end
      JALR_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        next_state = JAL;
      end
      JAL: begin
        pc_write = 1'b1;
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        next_state = ALU_WB;
      end
      default: next_state = state;
    endcase
    if (reset) {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_retired,
                alu_src_a, alu_src_b, alu_control, result_src} = '0;
  end
`ifdef ILLEGAL_TRAP_EN
  assign illegal_instr = state == TRAP && !reset;
`else
  assign illegal_instr = 1'b0;
`endif
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed checks of the multicycle control FSM
module tb_multicycle_controller;
  logic clk = 1'b0, reset = 1'b1;
  logic [6:0] opcode = 7'b0000011;
  logic [2:0] funct3 = 3'b000;
  logic funct7_5 = 1'b0, equal = 1'b0, less_than = 1'b0, less_than_unsigned = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_retired, illegal_instr;
  logic [1:0] alu_src_a, alu_src_b, result_src;
  logic [3:0] alu_control;
  logic [2:0] immediate_control;
  logic [17:0] ctl;
  int checks = 0, passed = 0, retired_cnt = 0, rw_cnt = 0;

  localparam logic [17:0] V_ZERO    = 18'b00000000_00_00_00_0000;
  localparam logic [17:0] V_FETCH   = 18'b10011000_00_10_10_0000;
  localparam logic [17:0] V_FWAIT   = 18'b10000000_00_10_10_0000;
  localparam logic [17:0] V_DECODE  = 18'b00000000_01_01_00_0000;
  localparam logic [17:0] V_MEMADR  = 18'b00000000_10_01_00_0000;
  localparam logic [17:0] V_MEMRD   = 18'b10100000_00_00_00_0000;
  localparam logic [17:0] V_MEMWB   = 18'b00000110_00_00_01_0000;
  localparam logic [17:0] V_MEMWR   = 18'b11100000_00_00_00_0000;
  localparam logic [17:0] V_MEMWRD  = 18'b11100010_00_00_00_0000;
  localparam logic [17:0] V_ALUWB   = 18'b00000110_00_00_00_0000;
  localparam logic [17:0] V_JAL     = 18'b00001000_01_10_00_0000;
  localparam logic [17:0] V_LUI     = 18'b00000000_11_01_00_0000;
  localparam logic [17:0] V_AUIPC   = 18'b00000000_01_01_00_0000;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .equal(equal), .less_than(less_than), .less_than_unsigned(less_than_unsigned),
    .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_control(alu_control), .result_src(result_src),
    .immediate_control(immediate_control), .instr_retired(instr_retired),
    .illegal_instr(illegal_instr)
  );

  assign ctl = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_retired,
                illegal_instr, alu_src_a, alu_src_b, result_src, alu_control};

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (instr_retired === 1'b1) retired_cnt++;
    if (reg_write === 1'b1) rw_cnt++;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7);
    opcode = op;
    funct3 = f3;
    funct7_5 = f7;
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if (ctl !== V_ZERO) $display("FAIL reset_outputs: got %b want %b", ctl, V_ZERO);
    else passed++;
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== V_FWAIT) $display("FAIL reset_release_fetch: got %b want %b", ctl, V_FWAIT);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_FWAIT) $display("FAIL fetch_wait_hold: got %b want %b", ctl, V_FWAIT);
    else passed++;
    tick();
  endtask

  task automatic test_load;
    logic [17:0] exp [5];
    int br, bw;
    exp = '{V_FETCH, V_DECODE, V_MEMADR, V_MEMRD, V_MEMWB};
    br = retired_cnt;
    bw = rw_cnt;
    set_instr(7'b0000011, 3'b010, 1'b0);
    mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== exp[i]) $display("FAIL lw_cycle%0d: got %b want %b", i + 1, ctl, exp[i]);
      else passed++;
      tick();
    end
    checks++;
    if (retired_cnt - br !== 1) $display("FAIL lw_retired: got %0d want 1", retired_cnt - br);
    else passed++;
    checks++;
    if (rw_cnt - bw !== 1) $display("FAIL lw_reg_write_count: got %0d want 1", rw_cnt - bw);
    else passed++;
  endtask

  task automatic test_store;
    int br, bw;
    br = retired_cnt;
    bw = rw_cnt;
    set_instr(7'b0100011, 3'b010, 1'b0);
    mem_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (immediate_control !== 3'b001) $display("FAIL sw_imm: got %b want 001", immediate_control);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_MEMADR) $display("FAIL sw_memadr: got %b want %b", ctl, V_MEMADR);
    else passed++;
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (ctl !== V_MEMWR) $display("FAIL sw_wait%0d: got %b want %b", i, ctl, V_MEMWR);
      else passed++;
      tick();
    end
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ctl !== V_MEMWRD) $display("FAIL sw_done: got %b want %b", ctl, V_MEMWRD);
    else passed++;
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (ctl !== V_FWAIT) $display("FAIL sw_back_to_fetch: got %b want %b", ctl, V_FWAIT);
    else passed++;
    tick();
    checks++;
    if (rw_cnt - bw !== 0 || retired_cnt - br !== 1)
      $display("FAIL sw_counts: reg_write %0d retired %0d want 0 1", rw_cnt - bw, retired_cnt - br);
    else passed++;
  endtask

  task automatic test_branch;
    logic [6:0] tbl [6];
    logic [17:0] exp;
    tbl = '{{3'b001, 1'b1, 1'b0, 1'b0, 1'b0}, {3'b110, 1'b0, 1'b0, 1'b1, 1'b1},
            {3'b000, 1'b1, 1'b0, 1'b0, 1'b1}, {3'b101, 1'b0, 1'b1, 1'b0, 1'b0},
            {3'b100, 1'b0, 1'b0, 1'b1, 1'b0}, {3'b111, 1'b0, 1'b1, 1'b0, 1'b1}};
    mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_instr(7'b1100011, tbl[i][6:4], 1'b0);
      {equal, less_than, less_than_unsigned} = tbl[i][3:1];
      tick();
      @(negedge clk);
      checks++;
      if (immediate_control !== 3'b010) $display("FAIL br%0d_imm: got %b want 010", i, immediate_control);
      else passed++;
      tick();
      exp = {4'b0000, tbl[i][0], 3'b010, 10'b0};
      @(negedge clk);
      checks++;
      if (ctl !== exp) $display("FAIL br%0d_f3_%b: got %b want %b", i, tbl[i][6:4], ctl, exp);
      else passed++;
      tick();
    end
    {equal, less_than, less_than_unsigned} = 3'b000;
  endtask

  task automatic test_alu;
    logic [15:0] tbl [12];
    logic [17:0] exp;
    tbl = '{{7'b0110011, 3'b000, 1'b1, 4'b0001, 1'b0}, {7'b0110011, 3'b000, 1'b0, 4'b0000, 1'b0},
            {7'b0110011, 3'b101, 1'b1, 4'b0111, 1'b0}, {7'b0010011, 3'b101, 1'b1, 4'b0111, 1'b0},
            {7'b0010011, 3'b101, 1'b0, 4'b0110, 1'b0}, {7'b0010011, 3'b000, 1'b1, 4'b0000, 1'b0},
            {7'b0010011, 3'b010, 1'b0, 4'b1000, 1'b0}, {7'b0110011, 3'b011, 1'b0, 4'b1001, 1'b0},
            {7'b0110011, 3'b111, 1'b0, 4'b0010, 1'b0}, {7'b0010011, 3'b110, 1'b0, 4'b0011, 1'b0},
            {7'b0110011, 3'b100, 1'b0, 4'b0100, 1'b0}, {7'b0110011, 3'b001, 1'b0, 4'b0101, 1'b0}};
    mem_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      set_instr(tbl[i][15:9], tbl[i][8:6], tbl[i][5]);
      tick();
      tick();
      exp = {8'b0, 2'b10, (tbl[i][15:9] == 7'b0110011) ? 2'b00 : 2'b01, 2'b00, tbl[i][4:1]};
      @(negedge clk);
      checks++;
      if (ctl !== exp) $display("FAIL alu%0d_exec: got %b want %b", i, ctl, exp);
      else passed++;
      tick();
      @(negedge clk);
      checks++;
      if (ctl !== V_ALUWB) $display("FAIL alu%0d_wb: got %b want %b", i, ctl, V_ALUWB);
      else passed++;
      tick();
    end
  endtask

  task automatic test_jump_upper;
    mem_ready = 1'b1;
    set_instr(7'b1101111, 3'b000, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if ({ctl, immediate_control} !== {V_DECODE, 3'b011})
      $display("FAIL jal_decode: got %b/%b want %b/011", ctl, immediate_control, V_DECODE);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_JAL) $display("FAIL jal_state: got %b want %b", ctl, V_JAL);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_ALUWB) $display("FAIL jal_wb: got %b want %b", ctl, V_ALUWB);
    else passed++;
    tick();
    set_instr(7'b1100111, 3'b000, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_MEMADR) $display("FAIL jalr_adr: got %b want %b", ctl, V_MEMADR);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_JAL) $display("FAIL jalr_jal: got %b want %b", ctl, V_JAL);
    else passed++;
    tick();
    tick();
    set_instr(7'b0110111, 3'b000, 1'b0);
    tick();
    @(negedge clk);
    checks++;
    if (immediate_control !== 3'b100) $display("FAIL lui_imm: got %b want 100", immediate_control);
    else passed++;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_LUI) $display("FAIL lui_state: got %b want %b", ctl, V_LUI);
    else passed++;
    tick();
    tick();
    set_instr(7'b0010111, 3'b000, 1'b0);
    tick();
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_AUIPC) $display("FAIL auipc_state: got %b want %b", ctl, V_AUIPC);
    else passed++;
    tick();
    tick();
  endtask

  task automatic test_illegal;
    logic [9:0] tbl [2];
    tbl = '{{7'b1111111, 3'b000}, {7'b1100011, 3'b010}};
    for (int i = 0; i < 2; i++) begin
      mem_ready = 1'b1;
      set_instr(tbl[i][9:3], tbl[i][2:0], 1'b0);
      tick();
`ifdef ILLEGAL_TRAP_EN
      @(negedge clk);
      checks++;
      if (ctl !== V_DECODE) $display("FAIL ill%0d_decode: got %b want %b", i, ctl, V_DECODE);
      else passed++;
      tick();
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        checks++;
        if (ctl !== 18'b00000001_00_00_00_0000)
          $display("FAIL ill%0d_trap%0d: got %b want %b", i, k, ctl, 18'b00000001_00_00_00_0000);
        else passed++;
        tick();
      end
      reset = 1'b1;
      #1;
      checks++;
      if (ctl !== V_ZERO) $display("FAIL ill%0d_reset: got %b want %b", i, ctl, V_ZERO);
      else passed++;
      tick();
      reset = 1'b0;
      mem_ready = 1'b0;
      #1;
      checks++;
      if (ctl !== V_FWAIT) $display("FAIL ill%0d_refetch: got %b want %b", i, ctl, V_FWAIT);
      else passed++;
      tick();
`else
      @(negedge clk);
      checks++;
      if (ctl !== 18'b00000010_01_01_00_0000)
        $display("FAIL ill%0d_nop: got %b want %b", i, ctl, 18'b00000010_01_01_00_0000);
      else passed++;
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (ctl !== V_FWAIT) $display("FAIL ill%0d_refetch: got %b want %b", i, ctl, V_FWAIT);
      else passed++;
      tick();
`endif
    end
  endtask

  task automatic test_reset_abort;
    int bw;
    set_instr(7'b0000011, 3'b010, 1'b0);
    mem_ready = 1'b1;
    tick();
    tick();
    mem_ready = 1'b0;
    tick();
    @(negedge clk);
    checks++;
    if (ctl !== V_MEMRD) $display("FAIL abort_memread_wait: got %b want %b", ctl, V_MEMRD);
    else passed++;
    bw = rw_cnt;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (ctl !== V_ZERO) $display("FAIL abort_async_zero: got %b want %b", ctl, V_ZERO);
    else passed++;
    tick();
    checks++;
    if (ctl !== V_ZERO) $display("FAIL abort_held_zero: got %b want %b", ctl, V_ZERO);
    else passed++;
    mem_ready = 1'b1;
    #2;
    reset = 1'b0;
    mem_ready = 1'b0;
    #1;
    checks++;
    if (ctl !== V_FWAIT) $display("FAIL abort_fetch: got %b want %b", ctl, V_FWAIT);
    else passed++;
    repeat (3) tick();
    checks++;
    if (rw_cnt - bw !== 0 || ctl !== V_FWAIT)
      $display("FAIL abort_no_writeback: reg_write %0d ctl %b want 0 %b", rw_cnt - bw, ctl, V_FWAIT);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int br, bw;
    br = retired_cnt;
    bw = rw_cnt;
    mem_ready = 1'b1;
    set_instr(7'b0110011, 3'b000, 1'b1);
    repeat (4) tick();
    set_instr(7'b0000011, 3'b010, 1'b0);
    repeat (5) tick();
    set_instr(7'b1100011, 3'b000, 1'b0);
    equal = 1'b1;
    repeat (3) tick();
    equal = 1'b0;
    mem_ready = 1'b0;
    checks++;
    if (retired_cnt - br !== 3 || rw_cnt - bw !== 2)
      $display("FAIL b2b_counts: retired %0d reg_write %0d want 3 2", retired_cnt - br, rw_cnt - bw);
    else passed++;
    @(negedge clk);
    checks++;
    if (ctl !== V_FWAIT) $display("FAIL b2b_end_fetch: got %b want %b", ctl, V_FWAIT);
    else passed++;
    tick();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_alu();
    test_jump_upper();
    test_illegal();
    test_reset_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
